switch_input: RTL

Input conditioning stage between the board switches and the processor register file. It takes the n+1 raw, asynchronous switch lines (sw7..sw0 as the data byte, sw8 as the handshake/"go" switch) and synchronises and debounces each one. It presents a clean, registered `data_in` bus that the register file maps onto registers %30 (sw8) and %31 (sw7..0). It also produces single-cycle rise/fall event pulses for sw8 for use by control/step logic.

---
 rtl/switch_input.sv | 88 ++++++++
 1 files changed

// File: rtl/switch_input.sv
// Switch conditioning: per-bit 2-flop synchroniser, optional debounce, sw8 edge pulses.
// Define SWITCH_INPUT_DEBOUNCE_EN to build the per-bit debounce counters.
module switch_input #(
    parameter int n         = 8,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [n:0] sw_in,
    output logic [n:0] data_in,
    output logic       sw8_rise,
    output logic       sw8_fall
);

    localparam int W = n + 1;

    logic [n:0] r_s1;
    logic [n:0] r_s2;
    logic [n:0] r_db;
    logic [n:0] w_db_next;
    logic       r_rise;
    logic       r_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
        end
    end

`ifdef SWITCH_INPUT_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] r_cnt      [W];
    logic [CW-1:0] w_cnt_next [W];

    // Any agreeing cycle clears the count, so bounces never accumulate.
    always_comb begin
        w_db_next = r_db;
        for (int i = 0; i < W; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (r_s2[i] == r_db[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
                w_db_next[i]  = r_s2[i];
                w_cnt_next[i] = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end
`else
    assign w_db_next = r_s2;
`endif

    // Pulses are derived from the next state so they line up with the data_in change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db   <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_db   <= w_db_next;
            r_rise <= w_db_next[n] & ~r_db[n];
            r_fall <= ~w_db_next[n] & r_db[n];
        end
    end

    assign data_in  = r_db;
    assign sw8_rise = r_rise;
    assign sw8_fall = r_fall;

endmodule
